ct_f_spsram_ctrl: RTL and testbench

- Initiator-side controller for the single-port FPGA SRAM wrappers (low-active A/CEN/GWEN/WEN/D/Q interface, 1-cycle registered read).
- Converts a valid/ready request port plus a valid/ready read-response port into SRAM cycles.
- After reset, zero-initialises the whole array. Supports per-segment masked writes at WRAP_SIZE granularity.
- Sits between a cache/buffer pipeline and one ct_f_spsram_* instance.

---
 rtl/ct_f_spsram_ctrl_pkg.sv | 42 ++++
 rtl/ct_f_spsram_rsp_hold.sv | 57 +++++
 rtl/ct_f_spsram_ctrl.sv | 156 +++++++++++++++
 tb/tb_ct_f_spsram_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_ctrl_pkg
//  Description : Shared types and helpers for the single-port SRAM
//                controller: controller state encoding, segment count and
//                segment-mask to active-low bit write-enable expansion.
//  Revision    : 1.0 - initial release
// ============================================================================
package ct_f_spsram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    // Upper bound on DATA_WIDTH supported by the mask expansion helper.
    localparam int MAX_DATA_WIDTH = 1024;

    function automatic int seg_count(input int data_width, input int wrap_size);
        return data_width / wrap_size;
    endfunction

    // Bit i of the result is the active-low write enable of data bit i,
    // i.e. the inverse of the mask bit of the segment that owns bit i.
    function automatic logic [MAX_DATA_WIDTH-1:0] seg_mask_to_wen(
        input logic [MAX_DATA_WIDTH-1:0] seg_mask,
        input int                        wrap_size
    );
        logic [MAX_DATA_WIDTH-1:0] wen;
        logic [9:0]                bit_idx;
        logic [9:0]                seg_idx;
        wen = '1;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            bit_idx      = 10'(i);
            seg_idx      = 10'(i / wrap_size);
            wen[bit_idx] = ~seg_mask[seg_idx];
        end
        return wen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_f_spsram_rsp_hold.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_rsp_hold
//  Description : One-entry read response holding register. The response is
//                presented straight from sram_q in the cycle after the read;
//                if the consumer stalls, sram_q is captured and the response
//                is served from the holding register until accepted.
//  Ports       : forever_cpuclk / cpurst_b - clock, async active-low reset
//                rd_fire   - a read was issued to the SRAM this cycle
//                rsp_rdy   - consumer accepts the response
//                sram_q    - SRAM read data (valid the cycle after a read)
//                rsp_vld   - response valid
//                rsp_rdata - response data (0 while nothing is pending)
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_f_spsram_rsp_hold #(
    parameter int DATA_WIDTH = 96
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_fire,
    input  logic                  rsp_rdy,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    logic                  r_vld;
    logic                  r_held;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  w_stall;

    assign w_stall = r_vld & ~rsp_rdy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_vld       <= 1'b0;
            r_held      <= 1'b0;
            r_hold_data <= '0;
        end else begin
            // rd_fire never coincides with a stall: the request port is
            // closed while the response is blocked.
            r_vld  <= rd_fire | w_stall;
            r_held <= ~rd_fire & w_stall;
            // sram_q is only meaningful in the first response cycle, so the
            // capture happens once, on the first stalled cycle.
            if (w_stall && !r_held) begin
                r_hold_data <= sram_q;
            end
        end
    end

    assign rsp_vld   = r_vld;
    assign rsp_rdata = r_held ? r_hold_data : (r_vld ? sram_q : '0);

endmodule
`default_nettype wire

// File: rtl/ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_ctrl
//  Description : Initiator-side controller for a single-port SRAM with a
//                low-active A/CEN/GWEN/WEN/D/Q interface and 1-cycle read.
//                Zero-fills the array after reset (INIT_EN=1), then maps a
//                valid/ready request port onto SRAM cycles and returns read
//                data over a valid/ready response port.
//  Ports       : forever_cpuclk / cpurst_b - clock, async active-low reset
//                req_*     - request port (wr, addr, wdata, segment wmask)
//                rsp_*     - read response port
//                init_done - array initialisation complete
//                sram_*    - SRAM macro interface (active-low controls)
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_f_spsram_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 96,
    parameter int WRAP_SIZE  = 24,
    parameter int INIT_EN    = 1
) (
    input  logic                                  forever_cpuclk,
    input  logic                                  cpurst_b,
    input  logic                                  req_vld,
    output logic                                  req_rdy,
    input  logic                                  req_wr,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [DATA_WIDTH-1:0]                 req_wdata,
    input  logic [DATA_WIDTH/WRAP_SIZE-1:0]       req_wmask,
    output logic                                  rsp_vld,
    input  logic                                  rsp_rdy,
    output logic [DATA_WIDTH-1:0]                 rsp_rdata,
    output logic                                  init_done,
    output logic [ADDR_WIDTH-1:0]                 sram_a,
    output logic                                  sram_cen,
    output logic                                  sram_gwen,
    output logic [DATA_WIDTH-1:0]                 sram_wen,
    output logic [DATA_WIDTH-1:0]                 sram_d,
    input  logic [DATA_WIDTH-1:0]                 sram_q
);

    localparam int          c_SEG_NUM   = seg_count(DATA_WIDTH, WRAP_SIZE);
    localparam ctrl_state_e c_RST_STATE = (INIT_EN != 0) ? INIT : RUN;
    localparam logic        c_RST_DONE  = (INIT_EN == 0);

    ctrl_state_e               r_state;
    ctrl_state_e               w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_init_cnt;
    logic                      r_init_done;
    // Low during reset and the cycle reset is released, so every SRAM
    // control sits at its idle value until the first clock edge.
    logic                      r_active;
    logic                      w_init_wr;
    logic                      w_init_last;
    logic                      w_req_acc;
    logic                      w_rd_fire;
    logic [MAX_DATA_WIDTH-1:0] w_wen_full;
    logic [DATA_WIDTH-1:0]     w_wen_exp;
    logic                      unused_wen_hi;

    assign w_wen_full    = seg_mask_to_wen({{(MAX_DATA_WIDTH-c_SEG_NUM){1'b0}}, req_wmask}, WRAP_SIZE);
    assign w_wen_exp     = w_wen_full[DATA_WIDTH-1:0];
    assign unused_wen_hi = ^w_wen_full[MAX_DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= c_RST_STATE;
            r_init_cnt  <= '0;
            r_init_done <= c_RST_DONE;
            r_active    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_init_wr) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            end
            if (w_init_last) begin
                r_init_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_wr   = 1'b0;
        w_init_last = 1'b0;
        w_req_acc   = 1'b0;
        w_rd_fire   = 1'b0;
        req_rdy     = 1'b0;
        sram_a      = '0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_d      = '0;
        case (r_state)
            INIT: begin
                if (r_active) begin
                    w_init_wr = 1'b1;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = r_init_cnt;
                    if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                        w_init_last = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (r_active) begin
                    // Only one read may be in flight: close the port while
                    // a response is waiting on the consumer.
                    req_rdy   = ~(rsp_vld & ~rsp_rdy);
                    w_req_acc = req_vld & req_rdy;
                    if (w_req_acc) begin
                        sram_a = req_addr;
                        if (req_wr) begin
                            // A fully masked write is consumed without
                            // touching the SRAM.
                            if (|req_wmask) begin
                                sram_cen  = 1'b0;
                                sram_gwen = 1'b0;
                                sram_wen  = w_wen_exp;
                                sram_d    = req_wdata;
                            end
                        end else begin
                            sram_cen  = 1'b0;
                            w_rd_fire = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_RST_STATE;
            end
        endcase
    end

    assign init_done = r_init_done;

    ct_f_spsram_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .rd_fire        (w_rd_fire),
        .rsp_rdy        (rsp_rdy),
        .sram_q         (sram_q),
        .rsp_vld        (rsp_vld),
        .rsp_rdata      (rsp_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_f_spsram_ctrl
//  Description : Self-checking bench for ct_f_spsram_ctrl. A behavioural
//                SRAM model sits on the DUT's SRAM port; a reference memory
//                and pending-response model predict every output.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ct_f_spsram_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 96;
    localparam int WS    = 24;
    localparam int NSEG  = 4;
    localparam int DEPTH = 512;

    localparam logic [DW-1:0] ONES    = {DW{1'b1}};
    localparam logic [DW-1:0] ZERO    = {DW{1'b0}};
    localparam logic [DW-1:0] W5      = 96'hD3D3D3_C2C2C2_B1B1B1_AAAAAA;
    localparam logic [DW-1:0] EXP5    = 96'h000000_C2C2C2_000000_AAAAAA;
    localparam logic [DW-1:0] WEN0101 = 96'hFFFFFF_000000_FFFFFF_000000;
    localparam logic [DW-1:0] WEN0011 = 96'hFFFFFF_FFFFFF_000000_000000;
    localparam logic [DW-1:0] D1      = 96'h0123456789ABCDEF01234567;
    localparam logic [DW-1:0] D2      = 96'hFEDCBA9876543210FEDCBA98;
    localparam logic [DW-1:0] D3      = 96'h55AA55AA55AA55AA55AA55AA;
    localparam logic [DW-1:0] EXP3    = 96'h00000000000055AA55AA55AA;
    localparam logic [DW-1:0] D5      = 96'hCAFEBABEDEADBEEF12345678;
    localparam logic [DW-1:0] D7      = 96'h777777776666666655555555;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (INIT_EN=1)
    logic            req_vld, req_rdy, req_wr, rsp_vld, rsp_rdy, init_done;
    logic [AW-1:0]   req_addr, sram_a;
    logic [DW-1:0]   req_wdata, rsp_rdata, sram_wen, sram_d, sram_q;
    logic [NSEG-1:0] req_wmask;
    logic            sram_cen, sram_gwen;

    // Second instance (INIT_EN=0)
    logic            n_req_vld, n_req_rdy, n_req_wr, n_rsp_vld, n_rsp_rdy, n_init_done;
    logic [AW-1:0]   n_req_addr, n_sram_a;
    logic [DW-1:0]   n_req_wdata, n_rsp_rdata, n_sram_wen, n_sram_d, n_sram_q;
    logic [NSEG-1:0] n_req_wmask;
    logic            n_sram_cen, n_sram_gwen;

    ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS), .INIT_EN(1)) u_dut (
        .forever_cpuclk (clk),        .cpurst_b  (rst_n),
        .req_vld        (req_vld),    .req_rdy   (req_rdy),
        .req_wr         (req_wr),     .req_addr  (req_addr),
        .req_wdata      (req_wdata),  .req_wmask (req_wmask),
        .rsp_vld        (rsp_vld),    .rsp_rdy   (rsp_rdy),
        .rsp_rdata      (rsp_rdata),  .init_done (init_done),
        .sram_a         (sram_a),     .sram_cen  (sram_cen),
        .sram_gwen      (sram_gwen),  .sram_wen  (sram_wen),
        .sram_d         (sram_d),     .sram_q    (sram_q)
    );

    ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS), .INIT_EN(0)) u_dut_noinit (
        .forever_cpuclk (clk),          .cpurst_b  (rst_n),
        .req_vld        (n_req_vld),    .req_rdy   (n_req_rdy),
        .req_wr         (n_req_wr),     .req_addr  (n_req_addr),
        .req_wdata      (n_req_wdata),  .req_wmask (n_req_wmask),
        .rsp_vld        (n_rsp_vld),    .rsp_rdy   (n_rsp_rdy),
        .rsp_rdata      (n_rsp_rdata),  .init_done (n_init_done),
        .sram_a         (n_sram_a),     .sram_cen  (n_sram_cen),
        .sram_gwen      (n_sram_gwen),  .sram_wen  (n_sram_wen),
        .sram_d         (n_sram_d),     .sram_q    (n_sram_q)
    );

    // Behavioural SRAM: q is only defined the cycle after a read; at other
    // times it is scrambled so stale data cannot pass unnoticed.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen && sram_gwen) sram_q <= mem[sram_a];
        else                        sram_q <= {$urandom, $urandom, $urandom};
        if (!sram_cen && !sram_gwen)
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end

    // Reference model state
    logic [DW-1:0]   ref_mem [DEPTH];
    bit              m_vld;
    logic [DW-1:0]   m_data;
    bit              c_acc, c_wr, c_rrdy;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_wdata;
    logic [NSEG-1:0] c_mask;

    int n_checks;
    int n_fails;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] seg_wen(input logic [NSEG-1:0] m);
        logic [DW-1:0] r;
        for (int s = 0; s < NSEG; s++) r[s*WS +: WS] = {WS{~m[s]}};
        return r;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NSEG-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int s = 0; s < NSEG; s++) if (m[s]) r[s*WS +: WS] = d[s*WS +: WS];
        return r;
    endfunction

    // Apply one cycle's inputs (called at the falling edge) and check every
    // output against the model.
    task automatic drive(input bit vld, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [NSEG-1:0] mask, input bit rrdy);
        bit exp_rdy;
        req_vld = vld; req_wr = wr; req_addr = addr; req_wdata = wdata;
        req_wmask = mask; rsp_rdy = rrdy;
        #1;
        exp_rdy = !(m_vld && !rrdy);
        check("req_rdy", {95'd0, req_rdy}, {95'd0, exp_rdy});
        check("rsp_vld", {95'd0, rsp_vld}, {95'd0, m_vld});
        if (m_vld) check("rsp_rdata", rsp_rdata, m_data);
        n_checks++;
        if ($isunknown({sram_a, sram_cen, sram_gwen, sram_wen, sram_d})) begin
            n_fails++;
            $display("FAIL sram_no_x @%0t: got X on SRAM outputs expected known values", $time);
        end
        c_acc = vld && exp_rdy; c_wr = wr; c_addr = addr; c_wdata = wdata;
        c_mask = mask; c_rrdy = rrdy;
        if (c_acc && !wr) begin
            check("rd_cen",  {95'd0, sram_cen},  ZERO);
            check("rd_gwen", {95'd0, sram_gwen}, {95'd0, 1'b1});
            check("rd_wen",  sram_wen, ONES);
            check("rd_a",    {87'd0, sram_a}, {87'd0, addr});
        end else if (c_acc && wr && mask != '0) begin
            check("wr_cen",  {95'd0, sram_cen},  ZERO);
            check("wr_gwen", {95'd0, sram_gwen}, ZERO);
            check("wr_wen",  sram_wen, seg_wen(mask));
            check("wr_a",    {87'd0, sram_a}, {87'd0, addr});
            check("wr_d",    sram_d, wdata);
        end else begin
            check("idle_cen",  {95'd0, sram_cen},  {95'd0, 1'b1});
            check("idle_gwen", {95'd0, sram_gwen}, {95'd0, 1'b1});
            check("idle_wen",  sram_wen, ONES);
        end
    endtask

    task automatic advance();
        if (c_acc && c_wr) ref_mem[c_addr] = merge(ref_mem[c_addr], c_wdata, c_mask);
        if (c_acc && !c_wr) begin
            m_vld  = 1'b1;
            m_data = ref_mem[c_addr];
        end else if (!(m_vld && !c_rrdy)) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_req_rdy",   {95'd0, req_rdy},   ZERO);
        check("rst_rsp_vld",   {95'd0, rsp_vld},   ZERO);
        check("rst_rsp_rdata", rsp_rdata,          ZERO);
        check("rst_init_done", {95'd0, init_done}, ZERO);
        check("rst_cen",       {95'd0, sram_cen},  {95'd0, 1'b1});
        check("rst_gwen",      {95'd0, sram_gwen}, {95'd0, 1'b1});
        check("rst_wen",       sram_wen,           ONES);
        check("rst_a",         {87'd0, sram_a},    ZERO);
        check("rst_d",         sram_d,             ZERO);
    endtask

    task automatic check_init_cycle(input int k);
        check("init_cen",       {95'd0, sram_cen},  ZERO);
        check("init_gwen",      {95'd0, sram_gwen}, ZERO);
        check("init_wen",       sram_wen,           ZERO);
        check("init_d",         sram_d,             ZERO);
        check("init_a",         {87'd0, sram_a},    DW'(k));
        check("init_req_rdy",   {95'd0, req_rdy},   ZERO);
        check("init_done_low",  {95'd0, init_done}, ZERO);
    endtask

    typedef struct {
        bit              vld;
        bit              wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [NSEG-1:0] mask;
        bit              exp_cen;
        bit              exp_gwen;
        logic [DW-1:0]   exp_wen;
        bit              exp_rvld;
        logic [DW-1:0]   exp_rdata;
    } vec_t;

    vec_t tbl [14];

    initial begin
        n_checks = 0; n_fails = 0;
        m_vld = 1'b0; m_data = '0;
        c_acc = 1'b0; c_wr = 1'b0; c_rrdy = 1'b1; c_addr = '0; c_wdata = '0; c_mask = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        tbl[0]  = '{1'b1, 1'b1, 9'd5, W5,   4'b0101, 1'b0, 1'b0, WEN0101, 1'b0, ZERO};
        tbl[1]  = '{1'b1, 1'b1, 9'd1, D1,   4'b1111, 1'b0, 1'b0, ZERO,    1'b0, ZERO};
        tbl[2]  = '{1'b1, 1'b1, 9'd2, D2,   4'b1111, 1'b0, 1'b0, ZERO,    1'b0, ZERO};
        tbl[3]  = '{1'b1, 1'b1, 9'd3, D3,   4'b0011, 1'b0, 1'b0, WEN0011, 1'b0, ZERO};
        tbl[4]  = '{1'b1, 1'b0, 9'd5, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b0, ZERO};
        tbl[5]  = '{1'b1, 1'b0, 9'd1, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b1, EXP5};
        tbl[6]  = '{1'b1, 1'b0, 9'd2, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b1, D1};
        tbl[7]  = '{1'b1, 1'b0, 9'd3, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b1, D2};
        tbl[8]  = '{1'b1, 1'b1, 9'd9, D5,   4'b0000, 1'b1, 1'b1, ONES,    1'b1, EXP3};
        tbl[9]  = '{1'b1, 1'b0, 9'd9, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b0, ZERO};
        tbl[10] = '{1'b0, 1'b0, 9'd0, ZERO, 4'b0000, 1'b1, 1'b1, ONES,    1'b1, ZERO};
        tbl[11] = '{1'b1, 1'b1, 9'd5, D5,   4'b1111, 1'b0, 1'b0, ZERO,    1'b0, ZERO};
        tbl[12] = '{1'b1, 1'b0, 9'd5, ZERO, 4'b0000, 1'b0, 1'b1, ONES,    1'b0, ZERO};
        tbl[13] = '{1'b0, 1'b0, 9'd0, ZERO, 4'b0000, 1'b1, 1'b1, ONES,    1'b1, D5};

        rst_n = 1'b0;
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b0;
        n_req_vld = 1'b0; n_req_wr = 1'b0; n_req_addr = '0; n_req_wdata = '0; n_req_wmask = '0;
        n_rsp_rdy = 1'b1; n_sram_q = '0;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        check("noinit_rst_done",    {95'd0, n_init_done}, {95'd0, 1'b1});
        check("noinit_rst_req_rdy", {95'd0, n_req_rdy},   ZERO);
        check("noinit_rst_cen",     {95'd0, n_sram_cen},  {95'd0, 1'b1});

        // ---- partial init, reset at counter 200 ----
        @(negedge clk);
        rst_n = 1'b1;
        req_vld = 1'b1; rsp_rdy = 1'b1;   // must be ignored during init
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 200; k++) begin
            if (k == 0) begin
                n_req_vld = 1'b1; n_req_wr = 1'b1; n_req_addr = 9'd3;
                n_req_wdata = D1; n_req_wmask = 4'b0000;
            end else begin
                n_req_vld = 1'b0;
            end
            #1;
            check_init_cycle(k);
            if (k == 0) begin
                check("noinit_done",     {95'd0, n_init_done}, {95'd0, 1'b1});
                check("noinit_req_rdy",  {95'd0, n_req_rdy},   {95'd0, 1'b1});
                check("noinit_mask0_cen",  {95'd0, n_sram_cen},  {95'd0, 1'b1});
                check("noinit_mask0_gwen", {95'd0, n_sram_gwen}, {95'd0, 1'b1});
            end
            if (k == 1) begin
                check("noinit_no_rsp",   {95'd0, n_rsp_vld}, ZERO);
                check("noinit_req_rdy2", {95'd0, n_req_rdy}, {95'd0, 1'b1});
            end
            if (k < 200) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();

        // ---- full init from address 0 ----
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check_init_cycle(k);
            @(negedge clk);
        end
        req_vld = 1'b0;
        #1;
        check("init_done_set", {95'd0, init_done}, {95'd0, 1'b1});
        check("run_req_rdy",   {95'd0, req_rdy},   {95'd0, 1'b1});
        @(negedge clk);

        // ---- directed vector table ----
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mask, 1'b1);
            check("tbl_req_rdy", {95'd0, req_rdy},   {95'd0, 1'b1});
            check("tbl_cen",     {95'd0, sram_cen},  {95'd0, tbl[i].exp_cen});
            check("tbl_gwen",    {95'd0, sram_gwen}, {95'd0, tbl[i].exp_gwen});
            check("tbl_wen",     sram_wen,           tbl[i].exp_wen);
            check("tbl_rsp_vld", {95'd0, rsp_vld},   {95'd0, tbl[i].exp_rvld});
            if (tbl[i].exp_rvld) check("tbl_rdata", rsp_rdata, tbl[i].exp_rdata);
            advance();
        end

        // ---- stalled response: read 7, hold rsp_rdy low for 4 cycles ----
        drive(1'b1, 1'b1, 9'd7, D7, 4'b1111, 1'b1); advance();
        drive(1'b1, 1'b0, 9'd7, ZERO, 4'b0000, 1'b1); advance();
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b0, 9'd8, ZERO, 4'b0000, 1'b0);
            check("stall_req_rdy", {95'd0, req_rdy}, ZERO);
            check("stall_rdata",   rsp_rdata,        D7);
            advance();
        end
        drive(1'b1, 1'b0, 9'd8, ZERO, 4'b0000, 1'b1);
        check("release_req_rdy", {95'd0, req_rdy}, {95'd0, 1'b1});
        check("release_rd_cen",  {95'd0, sram_cen}, ZERO);
        advance();
        drive(1'b0, 1'b0, 9'd0, ZERO, 4'b0000, 1'b1); advance();
        drive(1'b0, 1'b0, 9'd0, ZERO, 4'b0000, 1'b1); advance();

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom}, NSEG'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
            advance();
        end
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b0, 9'd0, ZERO, 4'b0000, 1'b1);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
